// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD types, FSM states and digit-range helper
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, MUL, DONE} state_t;
  typedef logic [3:0] digit_t;
  localparam digit_t BCD_MAX_DIGIT = 4'd9;
  function automatic logic bcd_bad(digit_t d);
    return d > BCD_MAX_DIGIT;
  endfunction
endpackage

// File: rtl/BCDMultiplier.sv
// BCDMultiplier: one-digit BCD multiply, x*y as two BCD digits {hi,lo}
module BCDMultiplier
  import bcd_pkg::*;
(
  input  digit_t x,
  input  digit_t y,
  output digit_t hi,
  output digit_t lo,
  output logic   x_ok,
  output logic   y_ok
);
  logic [7:0] m;
  assign m = {4'b0, x} * {4'b0, y};
  assign hi = 4'(m / 8'd10);
  assign lo = 4'(m % 8'd10);
  assign x_ok = !bcd_bad(x);
  assign y_ok = !bcd_bad(y);
endmodule

// File: rtl/bcd_mult_seq.sv
// bcd_mult_seq: sequential NDIG-digit x 1-digit BCD multiplier, one digit per cycle
// BCD_ERR_IDX_EN adds err_idx, the position of the lowest invalid input digit
module bcd_mult_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*NDIG-1:0]     a,
  input  logic [3:0]            b,
  output logic                  busy,
  output logic                  done,
  output logic [4*(NDIG+1)-1:0] p,
`ifdef BCD_ERR_IDX_EN
  output logic [3:0]            err_idx,
`endif
  output logic                  err
);
  state_t state, nxt;
  logic [4*NDIG-1:0] ar;
  digit_t br, carry, hi, lo, dig, ncarry;
  logic [3:0] i;
  logic [4:0] s;
  logic [NDIG-1:0] bad_a;
  logic ge, any_bad, last, unused_x_ok, unused_y_ok;
  // ar shifts right each MUL cycle so the multiplier always sees a registered digit 0
  BCDMultiplier u_mul (
    .x(ar[3:0]),
    .y(br),
    .hi(hi),
    .lo(lo),
    .x_ok(unused_x_ok),
    .y_ok(unused_y_ok)
  );
  assign s = {1'b0, lo} + {1'b0, carry};
  assign ge = s >= 5'd10;
  assign dig = ge ? 4'(s - 5'd10) : s[3:0];
  assign ncarry = hi + {3'b0, ge};
  assign last = i == 4'(NDIG - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    bad_a = '0;
    for (int k = 0; k < NDIG; k++) bad_a[k] = bcd_bad(ar[4*k +: 4]);
  end
  assign any_bad = |bad_a || bcd_bad(br);
`ifdef BCD_ERR_IDX_EN
  logic [3:0] idx;
  always_comb begin
    idx = 4'(NDIG);
    for (int k = NDIG - 1; k >= 0; k--) idx = bad_a[k] ? 4'(k) : idx;
  end
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CHECK : IDLE;
      CHECK:   nxt = any_bad ? DONE : MUL;
      MUL:     nxt = last ? DONE : MUL;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ar <= '0;
      br <= '0;
      i <= '0;
      carry <= '0;
      p <= '0;
      err <= 1'b0;
`ifdef BCD_ERR_IDX_EN
      err_idx <= '0;
`endif
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          ar <= a;
          br <= b;
          p <= '0;
          err <= 1'b0;
`ifdef BCD_ERR_IDX_EN
          err_idx <= '0;
`endif
        end
        CHECK: begin
          i <= '0;
          carry <= '0;
          err <= any_bad;
`ifdef BCD_ERR_IDX_EN
          err_idx <= any_bad ? idx : 4'd0;
`endif
        end
        MUL: begin
          p[4*i +: 4] <= dig;
          carry <= ncarry;
          i <= i + 4'd1;
          ar <= ar >> 4;
          if (last) p[4*NDIG +: 4] <= ncarry;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_mult_seq.sv
// tb_bcd_mult_seq: directed self-checking bench for bcd_mult_seq with NDIG=4
module tb_bcd_mult_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] a = '0;
  logic [3:0] b = '0;
  logic busy, done, err;
  logic [19:0] p;
`ifdef BCD_ERR_IDX_EN
  logic [3:0] err_idx;
`endif
  int checks = 0, errors = 0, cyc = 0, ndone = 0, nref;
  logic [19:0] pref;

  bcd_mult_seq #(.NDIG(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .p(p),
`ifdef BCD_ERR_IDX_EN
    .err_idx(err_idx),
`endif
    .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) ndone++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start is driven for one cycle; a/b are then scrambled to prove they were registered
  task automatic launch(input logic [15:0] av, input logic [3:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hFFFF;
    b = 4'hF;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input logic [19:0] pexp,
                               input logic eexp, input logic [3:0] iexp);
    wait_done();
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_p"}, p, pexp);
    chk({tag, "_err"}, err, eexp);
`ifdef BCD_ERR_IDX_EN
    chk({tag, "_err_idx"}, err_idx, iexp);
`else
    if (iexp > 4'd8) $display("unexpected index %0d", iexp);
`endif
    chk({tag, "_busy_in_done"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_p_held"}, p, pexp);
    chk({tag, "_err_held"}, err, eexp);
  endtask

  initial begin
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_p", p, 20'h0);
    chk("reset_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(16'h1234, 4'h9);
    chk("basic_busy_check", busy, 1'b1);
    expect_result("basic", 6, 20'h11106, 1'b0, 4'd0);

    launch(16'h9999, 4'h9);
    expect_result("carry_chain", 6, 20'h89991, 1'b0, 4'd0);

    launch(16'h0000, 4'h7);
    expect_result("zero", 6, 20'h00000, 1'b0, 4'd0);

    launch(16'h12A4, 4'h3);
    expect_result("bad_a", 2, 20'h00000, 1'b1, 4'd1);

    launch(16'h0005, 4'hC);
    expect_result("bad_b", 2, 20'h00000, 1'b1, 4'd4);

    launch(16'h0987, 4'h6);
    expect_result("after_err", 6, 20'h05922, 1'b0, 4'd0);

    nref = ndone;
    launch(16'h1234, 4'h9);
    @(negedge clk);
    cyc++;
    a = 16'h1111;
    b = 4'h2;
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    expect_result("ignored_start", 6, 20'h11106, 1'b0, 4'd0);
    repeat (10) @(negedge clk);
    chk("ignored_one_done", ndone - nref, 1);
    chk("ignored_p_kept", p, 20'h11106);

    launch(16'h1234, 4'h9);
    repeat (3) @(negedge clk);
    pref = p;
    chk("mid_partial_p", pref, 20'h00006);
    nref = ndone;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_p", p, 20'h0);
    chk("mid_rst_done", done, 1'b0);
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", ndone - nref, 0);
    rst_n = 1'b1;
    a = 16'h9999;
    b = 4'h9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'h0;
    b = 4'h0;
    cyc = 1;
    chk("post_rst_accept", busy, 1'b1);
    expect_result("post_rst", 6, 20'h89991, 1'b0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_mult_seq.md
BCD_MULT_SEQ -- requirements
Module: bcd_mult_seq

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of BCD digits in operand a (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 4*NDIG bits: multi-digit BCD multiplicand; digit 0 is a[3:0] (least significant).
REQ-006 The block SHALL have port b, input, 4 bits: one-digit BCD multiplier.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-009 The block SHALL have port p, output, 4*(NDIG+1) bits: BCD product; digit k is p[4k+3:4k]; held until the next accepted start.
REQ-010 The block SHALL have port err, output, 1 bit: high with done when any input digit is greater than 9; held with p.

Function
REQ-011 The block SHALL implement FSM states IDLE, CHECK, MUL and DONE.
REQ-012 IDLE + start=1 SHALL register a and b, clear the accumulator and go to CHECK; later changes on a/b SHALL NOT affect the operation.
REQ-013 CHECK SHALL take 1 cycle: any digit > 9 -> DONE with p=0, err=1; otherwise -> MUL with i=0, carry=0.
REQ-014 MUL SHALL process one digit per cycle, i = 0..NDIG-1, using a single shared one-digit multiplier: {hi,lo} = a_i*b (two BCD digits).
REQ-015 Per MUL cycle: s = lo + carry (max 18); p digit i = s mod 10; next carry = hi + (s >= 10) (max 9).
REQ-016 After i = NDIG-1, p digit NDIG SHALL take the final carry, and the FSM SHALL go to DONE.
REQ-017 DONE SHALL assert done for exactly 1 cycle and then return to IDLE; the block SHALL accept a new start in the cycle after done.
REQ-018 Latency SHALL be fixed: done rises NDIG+2 cycles after the start-sampling edge on the valid path, and 2 cycles after it on the error path.
REQ-019 start while busy SHALL be ignored, with no queuing.
REQ-020 busy SHALL be high in CHECK, MUL and DONE, and low in IDLE.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, err=0, p=0, carry=0 and i=0, including mid-operation.
REQ-022 After rst_n is released, the first start SHALL be accepted on the first rising clk edge at which rst_n=1.

Configuration
REQ-023 With BCD_ERR_IDX_EN defined, the block SHALL add output err_idx (4 bits): index of the lowest invalid a digit, NDIG if only b is invalid, 0 when err=0; it SHALL be held with err.
REQ-024 Without BCD_ERR_IDX_EN, the err_idx port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package bcd_pkg SHALL hold the FSM state typedef, the BCD digit typedef (4 bits) and the constant BCD_MAX_DIGIT = 9.
REQ-026 The block SHALL instantiate the team's existing one-digit BCDMultiplier as its single sub-module: registered digit in, its validation bits unused (range is checked in CHECK).
REQ-027 The block SHALL NOT contain a second multiplier instance.

Verification
REQ-028 The bench SHALL cover: NDIG=4, a=0x1234, b=0x9, start 1 cycle -> done at +6, p=0x11106, err=0.
REQ-029 The bench SHALL cover: a=0x9999, b=0x9 -> p=0x89991 (carry chain through every digit); a=0x0000, b=0x7 -> p=0x00000.
REQ-030 The bench SHALL cover: a=0x12A4, b=0x3 -> done at +2, err=1, p=0; with BCD_ERR_IDX_EN, err_idx=1; a=0x0005, b=0xC -> err=1, err_idx=4.
REQ-031 The bench SHALL cover: a second start pulse 2 cycles into a busy operation -> ignored, with exactly one done and the first result unchanged.
REQ-032 The bench SHALL cover: rst_n low in cycle 3 of MUL -> immediately busy=0, p=0, no done; a new start after release -> correct result.
